// File: rtl/movimento_monitor_if.sv
// Segment-level bus from the movement display driver plus the monitor's status outputs.
// The driver side uses the master modport; the monitor uses the slave modport.
interface movimento_monitor_if #(
    parameter int CNT_W = 8
);
    logic             A7, B7, C7, D7, E7, F7, G7, P7;
    logic [2:0]       frame;
    logic             frame_valid;
    logic             locked;
    logic             err;
    logic             stall;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output A7, B7, C7, D7, E7, F7, G7, P7,
        input  frame, frame_valid, locked, err, stall, cycle_count, err_count
    );

    modport slave (
        input  A7, B7, C7, D7, E7, F7, G7, P7,
        output frame, frame_valid, locked, err, stall, cycle_count, err_count
    );
endinterface

// File: rtl/movimento_monitor.sv
// Tracks the six-frame movement animation on a 7-segment display, flagging
// out-of-order frames, stalls and counting completed animation cycles.
//
// state  | meaning
// SYNC   | waiting for any legal pattern to lock onto
// LOCKED | following the animation; expects same frame or its successor
module movimento_monitor #(
    parameter int STALL_LIMIT = 15,
    parameter int CNT_W       = 8
) (
    input  logic                clkd,
    input  logic                reset,
    movimento_monitor_if.slave  mon
);
    typedef enum logic {
        SYNC   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0]       STALL_MAX = 8'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL  = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       seg_q, seg_d;
    logic [2:0]       frame_q, frame_d;
    logic             frame_valid_q, frame_valid_d;
    logic             err_q, err_d;
    logic             stall_q, stall_d;
    logic [7:0]       stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             smp_valid;
    logic [2:0]       smp_frame;
    logic [2:0]       succ_frame;
    logic             smp_hold;
    logic             smp_advance;

    assign seg_d = {mon.A7, mon.B7, mon.C7, mon.D7, mon.E7, mon.F7, mon.G7, mon.P7};

    // Decode works only on the registered sample; the decimal point gates validity.
    always_comb begin
        smp_valid = 1'b0;
        smp_frame = 3'd0;
        if (seg_q[0]) begin
            case (seg_q[7:1])
                7'h01: begin smp_valid = 1'b1; smp_frame = 3'd0; end
                7'h4F: begin smp_valid = 1'b1; smp_frame = 3'd1; end
                7'h12: begin smp_valid = 1'b1; smp_frame = 3'd2; end
                7'h06: begin smp_valid = 1'b1; smp_frame = 3'd3; end
                7'h4C: begin smp_valid = 1'b1; smp_frame = 3'd4; end
                7'h24: begin smp_valid = 1'b1; smp_frame = 3'd5; end
                default: begin smp_valid = 1'b0; smp_frame = 3'd0; end
            endcase
        end
    end

    always_comb begin
        succ_frame  = (frame_q == 3'd5) ? 3'd0 : frame_q + 3'd1;
        smp_hold    = smp_valid && (smp_frame == frame_q);
        smp_advance = smp_valid && (smp_frame == succ_frame);
    end

    always_ff @(posedge clkd) begin
        if (reset) begin
            state_q       <= SYNC;
            seg_q         <= 8'd0;
            frame_q       <= 3'd0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
            stall_q       <= 1'b0;
            stall_cnt_q   <= 8'd0;
            cycle_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            seg_q         <= seg_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
            stall_q       <= stall_d;
            stall_cnt_q   <= stall_cnt_d;
            cycle_count_q <= cycle_count_d;
            err_count_q   <= err_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (smp_valid) state_d = LOCKED;
            LOCKED:  if (!(smp_hold || smp_advance)) state_d = SYNC;
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;
        err_d         = 1'b0;
        stall_cnt_d   = stall_cnt_q;
        cycle_count_d = cycle_count_q;
        err_count_d   = err_count_q;
        case (state_q)
            SYNC: begin
                if (smp_valid) begin
                    frame_d       = smp_frame;
                    frame_valid_d = 1'b1;
                    stall_cnt_d   = 8'd0;
                end else begin
                    frame_valid_d = 1'b0;
                end
            end
            LOCKED: begin
                if (smp_hold) begin
                    if (stall_cnt_q < STALL_MAX) stall_cnt_d = stall_cnt_q + 8'd1;
                end else if (smp_advance) begin
                    frame_d     = smp_frame;
                    stall_cnt_d = 8'd0;
                    if (smp_frame == 3'd0) cycle_count_d = cycle_count_q + CNT_ONE;
                end else begin
                    // The offending sample is dropped; relock waits for the next one.
                    err_d         = 1'b1;
                    frame_valid_d = 1'b0;
                    stall_cnt_d   = 8'd0;
                    if (err_count_q != CNT_FULL) err_count_d = err_count_q + CNT_ONE;
                end
            end
            default: begin
                frame_valid_d = 1'b0;
            end
        endcase
        stall_d = (state_d == LOCKED) && (stall_cnt_d == STALL_MAX);
    end

    assign mon.frame       = frame_q;
    assign mon.frame_valid = frame_valid_q;
    assign mon.locked      = (state_q == LOCKED);
    assign mon.err         = err_q;
    assign mon.stall       = stall_q;
    assign mon.cycle_count = cycle_count_q;
    assign mon.err_count   = err_count_q;
endmodule

// File: tb/tb_movimento_monitor.sv
// Scoreboard bench for movimento_monitor: directed segment vectors with
// hand-computed expectations, checked two edges after each vector is applied.
module tb_movimento_monitor;
    localparam int CW = 2;

    typedef struct {
        int             due;
        logic [2:0]     f;
        logic           fv;
        logic           lk;
        logic           er;
        logic           st;
        logic [CW-1:0]  cc;
        logic [CW-1:0]  ec;
        string          name;
    } exp_t;

    logic clkd  = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    logic [6:0] tbl [6];

    always #5 clkd = ~clkd;

    movimento_monitor_if #(.CNT_W(CW)) bus ();

    movimento_monitor #(.STALL_LIMIT(15), .CNT_W(CW)) dut (
        .clkd  (clkd),
        .reset (reset),
        .mon   (bus)
    );

    task automatic set_seg(input logic [6:0] code, input logic p);
        {bus.A7, bus.B7, bus.C7, bus.D7, bus.E7, bus.F7, bus.G7} = code;
        bus.P7 = p;
    endtask

    task automatic push_exp(input int due, input logic [2:0] f, input logic fv, input logic lk,
                            input logic er, input logic st, input int cc, input int ec,
                            input string nm);
        exp_t e;
        e.due  = due;
        e.f    = f;
        e.fv   = fv;
        e.lk   = lk;
        e.er   = er;
        e.st   = st;
        e.cc   = CW'(cc);
        e.ec   = CW'(ec);
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic drive(input logic [6:0] code, input logic p, input logic [2:0] f,
                         input logic fv, input logic lk, input logic er, input logic st,
                         input int cc, input int ec, input string nm);
        @(negedge clkd);
        set_seg(code, p);
        push_exp(cyc + 2, f, fv, lk, er, st, cc, ec, nm);
    endtask

    // The reset edge overrides whatever the previous vector would have produced.
    task automatic do_reset(input string nm);
        @(negedge clkd);
        reset = 1'b1;
        set_seg(7'h00, 1'b0);
        if (q.size() > 0 && q[$].due == cyc + 1) void'(q.pop_back());
        push_exp(cyc + 1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, nm);
        push_exp(cyc + 2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, {nm, "_post"});
        @(negedge clkd);
        reset = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic [2+1+1+1+1+2*CW-1:0] got, req;
        forever begin
            @(posedge clkd);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e   = q.pop_front();
                got = {bus.frame, bus.frame_valid, bus.locked, bus.err, bus.stall,
                       bus.cycle_count, bus.err_count};
                req = {e.f, e.fv, e.lk, e.er, e.st, e.cc, e.ec};
                total++;
                if (got !== req || e.due != cyc) begin
                    bad++;
                    $display("FAIL %s @cyc %0d: got frame=%0d fv=%b lk=%b err=%b stall=%b cc=%0d ec=%0d, required frame=%0d fv=%b lk=%b err=%b stall=%b cc=%0d ec=%0d",
                             e.name, cyc, bus.frame, bus.frame_valid, bus.locked, bus.err,
                             bus.stall, bus.cycle_count, bus.err_count, e.f, e.fv, e.lk,
                             e.er, e.st, e.cc, e.ec);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = 7'h01; tbl[1] = 7'h4F; tbl[2] = 7'h12;
        tbl[3] = 7'h06; tbl[4] = 7'h4C; tbl[5] = 7'h24;
        set_seg(7'h00, 1'b0);

        do_reset("reset_init");

        // Full animation cycle from reset
        drive(7'h01, 1, 0, 1, 1, 0, 0, 0, 0, "seq_f0");
        drive(7'h4F, 1, 1, 1, 1, 0, 0, 0, 0, "seq_f1");
        drive(7'h12, 1, 2, 1, 1, 0, 0, 0, 0, "seq_f2");
        drive(7'h06, 1, 3, 1, 1, 0, 0, 0, 0, "seq_f3");
        drive(7'h4C, 1, 4, 1, 1, 0, 0, 0, 0, "seq_f4");
        drive(7'h24, 1, 5, 1, 1, 0, 0, 0, 0, "seq_f5");
        drive(7'h01, 1, 0, 1, 1, 0, 0, 1, 0, "seq_wrap_f0");

        // Skip from frame 2 to 4, then relock on the next 0x4C
        drive(7'h4F, 1, 1, 1, 1, 0, 0, 1, 0, "skip_f1");
        drive(7'h12, 1, 2, 1, 1, 0, 0, 1, 0, "skip_f2");
        drive(7'h4C, 1, 2, 0, 0, 1, 0, 1, 1, "skip_err");
        drive(7'h4C, 1, 4, 1, 1, 0, 0, 1, 1, "skip_relock");

        // Stall on a held frame 3
        drive(7'h24, 1, 5, 1, 1, 0, 0, 1, 1, "st_f5");
        drive(7'h01, 1, 0, 1, 1, 0, 0, 2, 1, "st_f0");
        drive(7'h4F, 1, 1, 1, 1, 0, 0, 2, 1, "st_f1");
        drive(7'h12, 1, 2, 1, 1, 0, 0, 2, 1, "st_f2");
        drive(7'h06, 1, 3, 1, 1, 0, 0, 2, 1, "st_f3");
        for (int i = 1; i <= 20; i++)
            drive(7'h06, 1, 3, 1, 1, 0, (i >= 15), 2, 1, $sformatf("stall_rep%0d", i));
        drive(7'h4C, 1, 4, 1, 1, 0, 0, 2, 1, "stall_release");

        // Violations of each kind; err_count saturates at 3
        drive(7'h24, 1, 5, 1, 1, 0, 0, 2, 1, "v_f5");
        drive(7'h12, 0, 5, 0, 0, 1, 0, 2, 2, "v_nodp");
        drive(7'h7F, 1, 5, 0, 0, 0, 0, 2, 2, "v_sync_invalid");
        drive(7'h01, 1, 0, 1, 1, 0, 0, 2, 2, "v_lock_f0_nocount");
        drive(7'h06, 1, 0, 0, 0, 1, 0, 2, 3, "v_nonsucc");
        drive(7'h4F, 1, 1, 1, 1, 0, 0, 2, 3, "v_lock_f1");
        drive(7'h4F, 0, 1, 0, 0, 1, 0, 2, 3, "v_sat");
        drive(7'h12, 1, 2, 1, 1, 0, 0, 2, 3, "v_lock_f2");

        // Advance to cycle_count 3, frame 5, then reset mid-stream
        drive(7'h06, 1, 3, 1, 1, 0, 0, 2, 3, "r_f3");
        drive(7'h4C, 1, 4, 1, 1, 0, 0, 2, 3, "r_f4");
        drive(7'h24, 1, 5, 1, 1, 0, 0, 2, 3, "r_f5");
        drive(7'h01, 1, 0, 1, 1, 0, 0, 3, 3, "r_f0");
        for (int fr = 1; fr <= 5; fr++)
            drive(tbl[fr], 1, 3'(fr), 1, 1, 0, 0, 3, 3, $sformatf("r2_f%0d", fr));
        do_reset("reset_mid");
        drive(7'h24, 1, 5, 1, 1, 0, 0, 0, 0, "post_relock_f5");
        drive(7'h01, 1, 0, 1, 1, 0, 0, 1, 0, "post_f0");

        // cycle_count wraps modulo 4
        for (int c = 2; c <= 4; c++) begin
            for (int fr = 1; fr <= 5; fr++)
                drive(tbl[fr], 1, 3'(fr), 1, 1, 0, 0, (c - 1) % 4, 0,
                      $sformatf("wrap%0d_f%0d", c, fr));
            drive(tbl[0], 1, 0, 1, 1, 0, 0, c % 4, 0, $sformatf("wrap%0d_f0", c));
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clkd);
        #2;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/movimento_monitor.md
MOVIMENTO_MONITOR -- requirements
Module: movimento_monitor

Interface
REQ-001 Parameter STALL_LIMIT, default 15: number of consecutive unchanged LOCKED samples at which stall asserts; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of cycle_count and err_count.
REQ-003 clkd  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 A7, B7, C7, D7, E7, F7, G7  input  1 each  segment levels from the movement display driver, clkd-synchronous.
REQ-006 P7  input  1  decimal-point level; must be 1 for any pattern to count as valid.
REQ-007 frame  output  3  decoded frame index 0..5.
REQ-008 frame_valid  output  1  frame holds a decode of a legal pattern.
REQ-009 locked  output  1  monitor is tracking the animation sequence.
REQ-010 err  output  1  one-cycle pulse on a sequence violation while locked.
REQ-011 stall  output  1  level; sequence has not advanced for STALL_LIMIT samples.
REQ-012 cycle_count  output  CNT_W  completed animation cycles, wrapping.
REQ-013 err_count  output  CNT_W  sequence violations, saturating.

Function
REQ-014 The block shall register {A7,B7,C7,D7,E7,F7,G7,P7} every cycle into an input stage; all decode and state logic shall use only the registered sample.
REQ-015 Pattern code is {A,B,C,D,E,F,G}, A as MSB; with P7=1 the legal codes are: 0x01 -> frame 0, 0x4F -> 1, 0x12 -> 2, 0x06 -> 3, 0x4C -> 4, 0x24 -> 5.
REQ-016 Any other code, or P7=0, is invalid.
REQ-017 The legal successor of frame n is n+1 for n = 0..4; the successor of 5 is 0.
REQ-018 Latency: a pattern present at the inputs before edge k shall be reflected on frame, frame_valid, locked, err and the counters after edge k+1.
REQ-019 The FSM shall have exactly two states, SYNC and LOCKED; locked=1 only in LOCKED.
REQ-020 SYNC, valid sample: load frame, set frame_valid=1, clear the stall counter, go to LOCKED; no counter changes.
REQ-021 SYNC, invalid sample: stay in SYNC with frame_valid=0; no err pulse and no counter change.
REQ-022 LOCKED, sample equal to the current frame: hold; increment the stall counter, saturating at STALL_LIMIT.
REQ-023 LOCKED, sample equal to the successor: update frame, clear the stall counter, clear stall.
REQ-024 REQ-023 qualifier: if the new frame is 0, also increment cycle_count, wrapping modulo 2^CNT_W.
REQ-025 LOCKED, invalid sample or valid non-successor frame: pulse err for one cycle and increment err_count, saturating at 2^CNT_W-1.
REQ-026 REQ-025 continuation: clear frame_valid, clear the stall counter and stall, return to SYNC; the offending sample is not reused for resync.
REQ-027 stall shall be 1 while the stall counter equals STALL_LIMIT and LOCKED; stall shall not cause an unlock.
REQ-028 err shall never be high on two consecutive cycles; a violation is a state change to SYNC, so the next possible err follows a new lock.
REQ-029 frame shall hold its last value whenever frame_valid=0.

Reset
REQ-030 While reset=1 at a clkd edge: input stage <- 0; state <- SYNC; frame, frame_valid, locked, err, stall, stall counter, cycle_count, err_count <- 0.
REQ-031 Reset mid-operation shall take priority over every REQ-020..REQ-027 transition in the same cycle; reset completes in one clkd edge.
REQ-032 The first legal sample after reset release shall lock per REQ-020 with latency per REQ-018.

Verification
REQ-033 Reset, then drive 0x01,0x4F,0x12,0x06,0x4C,0x24,0x01 with P7=1, one per cycle -> frame 0..5,0; locked from the 2nd output cycle; cycle_count=1; err never high.
REQ-034 While locked on frame 2 (0x12), drive 0x4C -> err high exactly one cycle; err_count=1; locked=0, frame_valid=0.
REQ-035 REQ-034 continuation: a following 0x4C -> relock on frame 4 with no further err.
REQ-036 Hold 0x06 for 20 cycles with STALL_LIMIT=15 -> stall rises on the 15th repeated sample, stays high; locked stays 1.
REQ-037 REQ-036 continuation: drive 0x4C -> stall drops on the same edge frame becomes 4.
REQ-038 Drive legal 0x12 with P7=0 while locked -> err pulse, SYNC; with CNT_W=2 force four violations -> err_count saturates at 3.
REQ-039 Assert reset for one cycle mid-stream at frame 5 with cycle_count=3 -> all outputs 0 next cycle; next 0x24 relocks at frame 5; cycle_count increments only on a later frame 0.
